ltc2311_emulator: RTL and testbench

LTC2311_EMULATOR -- requirements
Module: ltc2311_emulator

---
 rtl/ltc2311_emulator.sv | 155 +++++++++++++++
 tb/tb_ltc2311_emulator.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ltc2311_emulator.sv
// Emulates the digital side of an LTC2311 ADC: the reader requests a conversion with cnv_n,
// waits out busy, then clocks the captured 16-bit sample out on sdo MSB first using sck.
module ltc2311_emulator #(
  parameter int CONV_CYCLES = 45,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cnv_n,
  input  logic        sck,
  output logic        sdo,
  input  logic [15:0] sample_in,
  input  logic        pattern_en,
  input  logic        err_clr,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] conv_count,
  output logic        protocol_err
);

  localparam int CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CONV_LOAD = CNT_W'(CONV_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    CONVERT,
    READY,
    SHIFT,
    DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] cnv_sync_q, cnv_sync_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic                   cnv_prev_q, cnv_prev_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   cnv_fall_q, cnv_fall_d;
  logic                   sck_fall_q, sck_fall_d;
  logic [SYNC_STAGES:0]   live_q, live_d;
  logic [15:0]            shift_q, shift_d;
  logic [15:0]            ramp_q, ramp_d;
  logic [15:0]            conv_count_q, conv_count_d;
  logic [CNT_W-1:0]       conv_cnt_q, conv_cnt_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic                   frame_done_q, frame_done_d;
  logic                   err_q, err_d;
  logic                   start;
  logic                   err_set;

  // live_q fills with ones after reset so an edge is only reported once the edge
  // register holds a genuinely sampled pin value, never the reset preset.
  always_comb begin
    cnv_sync_d = {cnv_sync_q[SYNC_STAGES-2:0], cnv_n};
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], sck};
    cnv_prev_d = cnv_sync_q[SYNC_STAGES-1];
    sck_prev_d = sck_sync_q[SYNC_STAGES-1];
    live_d     = {live_q[SYNC_STAGES-1:0], 1'b1};
    cnv_fall_d = live_q[SYNC_STAGES] & cnv_prev_q & ~cnv_sync_q[SYNC_STAGES-1];
    sck_fall_d = live_q[SYNC_STAGES] & sck_prev_q & ~sck_sync_q[SYNC_STAGES-1];
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    ramp_d       = ramp_q;
    conv_count_d = conv_count_q;
    conv_cnt_d   = conv_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    frame_done_d = 1'b0;
    start        = 1'b0;
    err_set      = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (cnv_fall_q) start = 1'b1;
      end
      CONVERT: begin
        if (cnv_fall_q || sck_fall_q) err_set = 1'b1;
        if (conv_cnt_q == '0) state_d = READY;
        else                  conv_cnt_d = conv_cnt_q - CNT_W'(1);
      end
      READY, SHIFT: begin
        // A new conversion request outranks a coincident sck edge, which is dropped.
        if (cnv_fall_q) begin
          start   = 1'b1;
          err_set = 1'b1;
        end else if (sck_fall_q) begin
          shift_d = {shift_q[14:0], 1'b0};
          if (bit_cnt_q == 4'd15) begin
            state_d      = DONE;
            frame_done_d = 1'b1;
          end else begin
            state_d   = SHIFT;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d      = CONVERT;
      shift_d      = pattern_en ? ramp_q : sample_in;
      ramp_d       = pattern_en ? ramp_q + 16'd1 : ramp_q;
      conv_count_d = conv_count_q + 16'd1;
      conv_cnt_d   = CONV_LOAD;
      bit_cnt_d    = 4'd0;
    end

    err_d = err_set | (err_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnv_sync_q   <= '1;
      sck_sync_q   <= '1;
      cnv_prev_q   <= 1'b1;
      sck_prev_q   <= 1'b1;
      cnv_fall_q   <= 1'b0;
      sck_fall_q   <= 1'b0;
      live_q       <= '0;
      shift_q      <= '0;
      ramp_q       <= '0;
      conv_count_q <= '0;
      conv_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnv_sync_q   <= cnv_sync_d;
      sck_sync_q   <= sck_sync_d;
      cnv_prev_q   <= cnv_prev_d;
      sck_prev_q   <= sck_prev_d;
      cnv_fall_q   <= cnv_fall_d;
      sck_fall_q   <= sck_fall_d;
      live_q       <= live_d;
      shift_q      <= shift_d;
      ramp_q       <= ramp_d;
      conv_count_q <= conv_count_d;
      conv_cnt_q   <= conv_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign busy         = (state_q == CONVERT);
  assign sdo          = ((state_q == READY) || (state_q == SHIFT)) & shift_q[15];
  assign frame_done   = frame_done_q;
  assign conv_count   = conv_count_q;
  assign protocol_err = err_q;

endmodule

// File: tb/tb_ltc2311_emulator.sv
// Self-checking bench for ltc2311_emulator: a reader-level model predicts every output each
// cycle, and directed frames pin the model with hand-computed words, latencies and counts.
module tb_ltc2311_emulator;

  localparam int CC  = 45;
  localparam int SS  = 2;
  localparam int H   = 6;
  localparam int TMO = 2000;

  localparam int P_IDLE = 0;
  localparam int P_CONV = 1;
  localparam int P_READ = 2;
  localparam int P_DONE = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cnv_n = 1'b1;
  logic        sck = 1'b0;
  logic        pattern_en = 1'b0;
  logic        err_clr = 1'b0;
  logic [15:0] sample_in = 16'h0000;
  logic        sdo;
  logic        busy;
  logic        frame_done;
  logic [15:0] conv_count;
  logic        protocol_err;

  int nChecks = 0;
  int nFail = 0;
  int fdSeen = 0;
  int rampGen = 0;

  ltc2311_emulator #(.CONV_CYCLES(CC), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset_n(reset_n), .cnv_n(cnv_n), .sck(sck), .sdo(sdo),
    .sample_in(sample_in), .pattern_en(pattern_en), .err_clr(err_clr),
    .busy(busy), .frame_done(frame_done), .conv_count(conv_count),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reader-level model: pins become visible as edge events SS+2 clocks after they are
  // sampled; a conversion lasts CC clocks, then each sck fall hands out the next bit.
  int          cHist [SS+2];
  int          sHist [SS+2];
  int          mPhase = P_IDLE;
  int          mLeft = 0;
  int          mBits = 0;
  int          mRampSeen = 0;
  logic [15:0] mWord = 16'h0000;
  logic [15:0] mRamp = 16'h0000;
  logic [15:0] mCount = 16'h0000;
  logic        mErr = 1'b0;
  logic        mFd = 1'b0;
  logic        mValid = 1'b0;

  initial begin
    for (int i = 0; i < SS + 2; i++) begin
      cHist[i] = 2;
      sHist[i] = 2;
    end
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        mPhase = P_IDLE;
        mWord  = 16'h0000;
        mRamp  = 16'h0000;
        mCount = 16'h0000;
        mErr   = 1'b0;
        mFd    = 1'b0;
        mBits  = 0;
        mLeft  = 0;
        mValid = 1'b1;
        for (int i = 0; i < SS + 2; i++) begin
          cHist[i] = 2;
          sHist[i] = 2;
        end
      end else begin
        bit cEv, sEv, setErr;
        cEv    = (cHist[SS+1] == 1) && (cHist[SS] == 0);
        sEv    = (sHist[SS+1] == 1) && (sHist[SS] == 0);
        setErr = 1'b0;
        mFd    = 1'b0;
        if (rampGen != mRampSeen) begin
          mRamp     = 16'hFFFF;
          mRampSeen = rampGen;
        end
        if (cEv && mPhase != P_IDLE && mPhase != P_DONE) setErr = 1'b1;
        if (cEv && mPhase != P_CONV) begin
          mWord  = pattern_en ? mRamp : sample_in;
          if (pattern_en) mRamp = mRamp + 16'd1;
          mCount = mCount + 16'd1;
          mLeft  = CC;
          mBits  = 0;
          mPhase = P_CONV;
        end else if (mPhase == P_CONV) begin
          if (sEv) setErr = 1'b1;
          mLeft--;
          if (mLeft == 0) mPhase = P_READ;
        end else if (mPhase == P_READ && sEv) begin
          mBits++;
          if (mBits == 16) begin
            mPhase = P_DONE;
            mFd    = 1'b1;
          end
        end
        mErr = setErr ? 1'b1 : (err_clr ? 1'b0 : mErr);
        for (int i = SS + 1; i > 0; i--) begin
          cHist[i] = cHist[i-1];
          sHist[i] = sHist[i-1];
        end
        cHist[0] = int'(cnv_n);
        sHist[0] = int'(sck);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mValid) begin
        checkOutput("cyc_busy", busy, (mPhase == P_CONV));
        checkOutput("cyc_sdo", sdo, (mPhase == P_READ) ? mWord[15-mBits] : 1'b0);
        checkOutput("cyc_frame_done", frame_done, mFd);
        checkOutput("cyc_conv_count", conv_count, mCount);
        checkOutput("cyc_protocol_err", protocol_err, mErr);
      end
      if (frame_done === 1'b1) fdSeen++;
    end
  end

  task automatic applyStimulus(input logic c, input logic s, input int cycles);
    cnv_n = c;
    sck   = s;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic applyReset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (SS + 3) @(negedge clk);
  endtask

  task automatic waitBusy(input logic level, output int cycles);
    cycles = 0;
    while (busy !== level && cycles < TMO) begin
      @(negedge clk);
      cycles++;
    end
    if (cycles >= TMO) checkOutput("busy_wait_timeout", busy, level);
  endtask

  task automatic startConversion();
    int lat;
    applyStimulus(1'b1, sck, SS + 3);
    cnv_n = 1'b0;
    waitBusy(1'b1, lat);
    checkOutput("busy_latency", lat, SS + 2);
  endtask

  task automatic readBits(input int n, output logic [15:0] w);
    int d;
    w = 16'h0000;
    waitBusy(1'b0, d);
    repeat (2) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      sck = 1'b1;
      w[15-i] = sdo;
      repeat (H) @(negedge clk);
      sck = 1'b0;
      repeat (H) @(negedge clk);
    end
  endtask

  initial begin
    #1000000;
    nFail++;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    logic [15:0] w;
    int          fdBase;
    int          dur;
    bit          busySeen;

    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_sdo", sdo, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_frame_done", frame_done, 0);
    checkOutput("reset_conv_count", conv_count, 0);
    checkOutput("reset_protocol_err", protocol_err, 0);
    reset_n = 1'b1;
    repeat (SS + 4) @(negedge clk);

    $display("[TB] basic frame");
    sample_in = 16'hDEAD;
    fdBase = fdSeen;
    startConversion();
    dur = 0;
    while (busy === 1'b1 && dur < TMO) begin
      dur++;
      @(negedge clk);
    end
    checkOutput("busy_cycles", dur, CC);
    readBits(16, w);
    checkOutput("basic_word", w, 16'hDEAD);
    repeat (SS + 4) @(negedge clk);
    checkOutput("basic_frame_done_count", fdSeen - fdBase, 1);
    checkOutput("basic_conv_count", conv_count, 1);

    $display("[TB] ramp mode");
    applyReset();
    pattern_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      startConversion();
      readBits(16, w);
      checkOutput("ramp_word", w, i);
    end
    checkOutput("ramp_conv_count", conv_count, 3);
    force dut.ramp_q = 16'hFFFF;
    rampGen++;
    @(negedge clk);
    release dut.ramp_q;
    @(negedge clk);
    startConversion();
    readBits(16, w);
    checkOutput("ramp_word_ffff", w, 16'hFFFF);
    startConversion();
    readBits(16, w);
    checkOutput("ramp_word_wrap", w, 16'h0000);
    pattern_en = 1'b0;

    $display("[TB] early sck and cnv_n during convert");
    sample_in = 16'h1234;
    startConversion();
    repeat (5) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, H);
      applyStimulus(1'b0, 1'b0, H);
    end
    applyStimulus(1'b1, 1'b0, SS + 3);
    applyStimulus(1'b0, 1'b0, SS + 3);
    checkOutput("early_busy_held", busy, 1);
    checkOutput("early_err_set", protocol_err, 1);
    readBits(16, w);
    checkOutput("early_word", w, 16'h1234);
    checkOutput("early_err_sticky", protocol_err, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    checkOutput("early_err_cleared", protocol_err, 0);

    $display("[TB] frame abort");
    sample_in = 16'hBEEF;
    startConversion();
    readBits(8, w);
    checkOutput("abort_partial", w[15:8], 8'hBE);
    sample_in = 16'hC0DE;
    startConversion();
    checkOutput("abort_err", protocol_err, 1);
    readBits(16, w);
    checkOutput("abort_word", w, 16'hC0DE);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;

    $display("[TB] simultaneous cnv_n and sck edges");
    sample_in = 16'h5A5A;
    startConversion();
    waitBusy(1'b0, dur);
    applyStimulus(1'b1, 1'b1, H);
    applyStimulus(1'b0, 1'b0, 1);
    waitBusy(1'b1, dur);
    checkOutput("prio_busy", busy, 1);
    checkOutput("prio_err", protocol_err, 1);
    readBits(16, w);
    checkOutput("prio_word", w, 16'h5A5A);

    $display("[TB] reset mid-frame");
    sample_in = 16'h0F0F;
    startConversion();
    readBits(5, w);
    fdBase = fdSeen;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checkOutput("midreset_sdo", sdo, 0);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_conv_count", conv_count, 0);
    checkOutput("midreset_protocol_err", protocol_err, 0);
    busySeen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busySeen = 1'b1;
    end
    checkOutput("midreset_no_start", busySeen, 0);
    checkOutput("midreset_no_frame_done", fdSeen - fdBase, 0);
    startConversion();
    checkOutput("midreset_conv_count_after", conv_count, 1);
    readBits(16, w);
    checkOutput("midreset_word", w, 16'h0F0F);
    repeat (SS + 4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
